bmem_arbiter: RTL and testbench

Shares the single banked-memory port of the core between the instruction cache and the data cache. It arbitrates line-sized read and write requests, sequences 4-beat write bursts onto the bus, and steers read bursts back to the owning cache. Read bursts may return in any order, so steering is by returned address. It sits between `icache_inst`/`dcache_inst` and the `bmem_*` ports of `cpu`.

---
 rtl/bmem_pkg.sv | 18 +
 rtl/bmem_arbiter_if.sv | 42 ++++
 rtl/line_assembler.sv | 57 +++++
 rtl/bmem_arbiter.sv | 153 +++++++++++++++
 tb/tb_bmem_arbiter.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/bmem_pkg.sv
// Shared types and constants for the banked-memory arbiter.
package bmem_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned BEAT_W = 64;
    localparam int unsigned BEATS  = 4;
    localparam int unsigned LINE_W = BEATS * BEAT_W;
    localparam int unsigned CNT_W  = $clog2(BEATS);

    typedef enum logic [1:0] {IDLE, WBURST, WDONE} arb_state_t;
    typedef enum logic {OWN_I, OWN_D} owner_t;

    // Clear the byte-in-line offset bits of an address.
    function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] a);
        return a & ~(ADDR_W'(LINE_W / 8) - ADDR_W'(1));
    endfunction

endpackage

// File: rtl/bmem_arbiter_if.sv
// Cache-side and memory-side signals of the banked-memory arbiter.
interface bmem_arbiter_if;
    import bmem_pkg::*;

    logic [ADDR_W-1:0] i_addr;
    logic              i_read;
    logic [LINE_W-1:0] i_rdata;
    logic              i_resp;

    logic [ADDR_W-1:0] d_addr;
    logic              d_read;
    logic              d_write;
    logic [LINE_W-1:0] d_wdata;
    logic [LINE_W-1:0] d_rdata;
    logic              d_resp;

    logic [ADDR_W-1:0] bmem_addr;
    logic              bmem_read;
    logic              bmem_write;
    logic [BEAT_W-1:0] bmem_wdata;
    logic              bmem_ready;
    logic [ADDR_W-1:0] bmem_raddr;
    logic [BEAT_W-1:0] bmem_rdata;
    logic              bmem_rvalid;

    // Arbiter view.
    modport slave (
        input  i_addr, i_read, d_addr, d_read, d_write, d_wdata,
        input  bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid,
        output i_rdata, i_resp, d_rdata, d_resp,
        output bmem_addr, bmem_read, bmem_write, bmem_wdata
    );

    // Environment view: caches and memory.
    modport master (
        output i_addr, i_read, d_addr, d_read, d_write, d_wdata,
        output bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid,
        input  i_rdata, i_resp, d_rdata, d_resp,
        input  bmem_addr, bmem_read, bmem_write, bmem_wdata
    );

endinterface

// File: rtl/line_assembler.sv
// Tracks one outstanding read line and assembles its returning beats.
module line_assembler
    import bmem_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              issue,
    input  logic [ADDR_W-1:0] issue_addr,
    input  logic              rvalid,
    input  logic [ADDR_W-1:0] raddr,
    input  logic [BEAT_W-1:0] rdata,
    output logic              pend,
    output logic              hit,
    output logic              resp,
    output logic [LINE_W-1:0] line
);

    logic              pend_q;
    logic [ADDR_W-1:0] pend_addr_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [LINE_W-1:0] line_q;
    logic              resp_q;

    assign hit  = pend_q && (pend_addr_q == raddr);
    assign pend = pend_q;
    assign resp = resp_q;
    assign line = line_q;

    // Capture the pending address on issue; shift matching beats in from the top so that
    // beat 0 ends up in the low bits once the line is complete.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
            cnt_q       <= '0;
            line_q      <= '0;
            resp_q      <= 1'b0;
        end else begin
            resp_q <= 1'b0;
            if (issue) begin
                pend_q      <= 1'b1;
                pend_addr_q <= issue_addr;
            end
            if (rvalid && hit) begin
                line_q <= {rdata, line_q[LINE_W-1:BEAT_W]};
                if (cnt_q == CNT_W'(BEATS - 1)) begin
                    cnt_q  <= '0;
                    pend_q <= 1'b0;
                    resp_q <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/bmem_arbiter.sv
// Shares the banked-memory port between icache and dcache: round-robin grant, write burst
// sequencing and address-steered read return.
module bmem_arbiter
    import bmem_pkg::*;
(
    input logic          clk,
    input logic          rst,
    bmem_arbiter_if.slave bus
);

    arb_state_t        state_q;
    logic [CNT_W-1:0]  wcnt_q;
    logic [ADDR_W-1:0] wr_addr_q;
    owner_t            last_q;
    logic              wr_resp_q;

    // Performance counters, read hierarchically by the top-level report.
    logic [31:0] rx_drop;
    logic [31:0] i_grant_hk;
    logic [31:0] d_grant_hk;

    logic i_pend, d_pend, i_hit, d_hit, i_lresp, d_lresp;
    logic [LINE_W-1:0] i_line, d_line;

    logic i_elig, d_elig, grant_i, grant_d;
    logic i_issue, d_issue, d_wr_start;

    // Eligibility and round-robin grant; only IDLE grants.
    always_comb begin
        i_elig     = bus.i_read && !i_pend && !i_lresp;
        d_elig     = (bus.d_read || bus.d_write) && !d_pend && !(d_lresp || wr_resp_q);
        grant_d    = (state_q == IDLE) && d_elig && (!i_elig || last_q == OWN_I);
        grant_i    = (state_q == IDLE) && i_elig && !grant_d;
        i_issue    = grant_i && bus.bmem_ready;
        d_issue    = grant_d && bus.d_read && bus.bmem_ready;
        d_wr_start = grant_d && bus.d_write && bus.bmem_ready;
    end

    // Bus command outputs; held at zero while reset is asserted.
    always_comb begin
        bus.bmem_addr  = '0;
        bus.bmem_read  = 1'b0;
        bus.bmem_write = 1'b0;
        bus.bmem_wdata = '0;
        if (!rst) begin
            unique case (state_q)
                IDLE: begin
                    if (grant_d) begin
                        bus.bmem_addr = line_align(bus.d_addr);
                        if (bus.d_write) begin
                            bus.bmem_write = 1'b1;
                            bus.bmem_wdata = bus.d_wdata[BEAT_W*int'(wcnt_q) +: BEAT_W];
                        end else begin
                            bus.bmem_read = 1'b1;
                        end
                    end else if (grant_i) begin
                        bus.bmem_addr = line_align(bus.i_addr);
                        bus.bmem_read = 1'b1;
                    end
                end
                WBURST: begin
                    bus.bmem_addr  = wr_addr_q;
                    bus.bmem_write = 1'b1;
                    bus.bmem_wdata = bus.d_wdata[BEAT_W*int'(wcnt_q) +: BEAT_W];
                end
                default: ;
            endcase
        end
    end

    // Arbiter FSM, write beat counter, round-robin history and perf counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            wcnt_q     <= '0;
            wr_addr_q  <= '0;
            last_q     <= OWN_I;
            wr_resp_q  <= 1'b0;
            rx_drop    <= '0;
            i_grant_hk <= '0;
            d_grant_hk <= '0;
        end else begin
            wr_resp_q <= 1'b0;
            if (bus.bmem_rvalid && !i_hit && !d_hit) begin
                rx_drop <= rx_drop + 32'd1;
            end
            unique case (state_q)
                IDLE: begin
                    if (i_issue) begin
                        last_q     <= OWN_I;
                        i_grant_hk <= i_grant_hk + 32'd1;
                    end
                    if (d_issue || d_wr_start) begin
                        last_q     <= OWN_D;
                        d_grant_hk <= d_grant_hk + 32'd1;
                    end
                    if (d_wr_start) begin
                        state_q   <= WBURST;
                        wcnt_q    <= CNT_W'(1);
                        wr_addr_q <= line_align(bus.d_addr);
                    end
                end
                WBURST: begin
                    if (bus.bmem_ready) begin
                        if (wcnt_q == CNT_W'(BEATS - 1)) begin
                            state_q   <= WDONE;
                            wcnt_q    <= '0;
                            wr_resp_q <= 1'b1;
                        end else begin
                            wcnt_q <= wcnt_q + CNT_W'(1);
                        end
                    end
                end
                WDONE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    line_assembler u_i_asm (
        .clk       (clk),
        .rst       (rst),
        .issue     (i_issue),
        .issue_addr(line_align(bus.i_addr)),
        .rvalid    (bus.bmem_rvalid),
        .raddr     (bus.bmem_raddr),
        .rdata     (bus.bmem_rdata),
        .pend      (i_pend),
        .hit       (i_hit),
        .resp      (i_lresp),
        .line      (i_line)
    );

    line_assembler u_d_asm (
        .clk       (clk),
        .rst       (rst),
        .issue     (d_issue),
        .issue_addr(line_align(bus.d_addr)),
        .rvalid    (bus.bmem_rvalid),
        .raddr     (bus.bmem_raddr),
        .rdata     (bus.bmem_rdata),
        .pend      (d_pend),
        .hit       (d_hit),
        .resp      (d_lresp),
        .line      (d_line)
    );

    assign bus.i_resp  = i_lresp;
    assign bus.i_rdata = i_line;
    assign bus.d_resp  = d_lresp || wr_resp_q;
    assign bus.d_rdata = d_line;

endmodule

// File: tb/tb_bmem_arbiter.sv
// Directed bench for bmem_arbiter; inputs change on the falling edge, outputs are sampled
// 1 time unit later.
module tb_bmem_arbiter;
    import bmem_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int total = 0;
    int bad   = 0;

    bmem_arbiter_if bus();

    bmem_arbiter dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [BEAT_W-1:0] bv(input logic [15:0] tag, input int k);
        return {tag, 16'h0, 32'h1234_0000 + 32'(k)};
    endfunction

    function automatic logic [LINE_W-1:0] lv(input logic [15:0] tag);
        return {bv(tag, 3), bv(tag, 2), bv(tag, 1), bv(tag, 0)};
    endfunction

    // Four consecutive beats; leaves the bench one falling edge after the last beat.
    task automatic send_burst(input logic [ADDR_W-1:0] a, input logic [15:0] tag);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            bus.bmem_rvalid = 1'b1;
            bus.bmem_raddr  = a;
            bus.bmem_rdata  = bv(tag, k);
        end
        @(negedge clk);
        bus.bmem_rvalid = 1'b0;
        bus.bmem_raddr  = '0;
        bus.bmem_rdata  = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        bus.i_read = 1'b1; bus.d_read = 1'b1; bus.bmem_ready = 1'b1;
        bus.i_addr = 32'h40; bus.d_addr = 32'h80;
        #1;
        total++; if (bus.bmem_read !== 1'b0 || bus.bmem_write !== 1'b0) begin
            bad++; $display("FAIL reset_cmd: got r=%b w=%b want 0 0", bus.bmem_read, bus.bmem_write); end
        total++; if (bus.bmem_addr !== 32'h0) begin
            bad++; $display("FAIL reset_addr: got %h want 0", bus.bmem_addr); end
        total++; if (bus.i_resp !== 1'b0 || bus.d_resp !== 1'b0 || bus.i_rdata !== '0) begin
            bad++; $display("FAIL reset_resp: got i=%b d=%b want 0 0", bus.i_resp, bus.d_resp); end
        total++; if (dut.rx_drop !== 32'd0) begin
            bad++; $display("FAIL reset_drop: got %0d want 0", dut.rx_drop); end
        bus.i_read = 1'b0; bus.d_read = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_icache_read();
        @(negedge clk);
        bus.i_addr = 32'h1000_0044; bus.i_read = 1'b1; bus.bmem_ready = 1'b1;
        #1;
        total++; if (bus.bmem_read !== 1'b1 || bus.bmem_addr !== 32'h1000_0040) begin
            bad++; $display("FAIL ird_cmd: got r=%b a=%h want 1 10000040", bus.bmem_read, bus.bmem_addr); end
        @(negedge clk);
        bus.bmem_ready = 1'b0;
        #1;
        total++; if (bus.bmem_read !== 1'b0) begin
            bad++; $display("FAIL ird_noreissue: got %b want 0", bus.bmem_read); end
        send_burst(32'h1000_0040, 16'hA0A0);
        #1;
        total++; if (bus.i_resp !== 1'b1 || bus.i_rdata !== lv(16'hA0A0)) begin
            bad++; $display("FAIL ird_resp: got resp=%b data=%h want 1 %h", bus.i_resp, bus.i_rdata,
                            lv(16'hA0A0)); end
        total++; if (bus.bmem_read !== 1'b0 || bus.d_resp !== 1'b0) begin
            bad++; $display("FAIL ird_resp_cycle: got r=%b d=%b want 0 0", bus.bmem_read, bus.d_resp); end
        bus.i_read = 1'b0;
        @(negedge clk);
        #1;
        total++; if (bus.i_resp !== 1'b0) begin
            bad++; $display("FAIL ird_pulse: got %b want 0", bus.i_resp); end
    endtask

    task automatic test_tie();
        do_reset();
        @(negedge clk);
        bus.i_read = 1'b1; bus.i_addr = 32'h2000;
        bus.d_read = 1'b1; bus.d_addr = 32'h3000; bus.bmem_ready = 1'b1;
        #1;
        total++; if (bus.bmem_read !== 1'b1 || bus.bmem_addr !== 32'h3000) begin
            bad++; $display("FAIL tie_c0: got r=%b a=%h want 1 00003000", bus.bmem_read, bus.bmem_addr); end
        @(negedge clk);
        #1;
        total++; if (bus.bmem_read !== 1'b1 || bus.bmem_addr !== 32'h2000) begin
            bad++; $display("FAIL tie_c1: got r=%b a=%h want 1 00002000", bus.bmem_read, bus.bmem_addr); end
        @(negedge clk);
        bus.bmem_ready = 1'b0;
        #1;
        total++; if (bus.bmem_read !== 1'b0) begin
            bad++; $display("FAIL tie_c2: got %b want 0", bus.bmem_read); end
        send_burst(32'h3000, 16'hD0D0);
        #1;
        total++; if (bus.d_resp !== 1'b1 || bus.d_rdata !== lv(16'hD0D0) || bus.i_resp !== 1'b0) begin
            bad++; $display("FAIL tie_dresp: got d=%b i=%b data=%h want 1 0 %h", bus.d_resp, bus.i_resp,
                            bus.d_rdata, lv(16'hD0D0)); end
        bus.d_read = 1'b0;
        send_burst(32'h2000, 16'hC0C0);
        #1;
        total++; if (bus.i_resp !== 1'b1 || bus.i_rdata !== lv(16'hC0C0)) begin
            bad++; $display("FAIL tie_iresp: got i=%b data=%h want 1 %h", bus.i_resp, bus.i_rdata,
                            lv(16'hC0C0)); end
        bus.i_read = 1'b0;
    endtask

    task automatic test_write_stall();
        logic [6:0] pat = 7'b1100011;
        logic [BEAT_W-1:0] w [4];
        int idx = 0;
        for (int k = 0; k < 4; k++) w[k] = bv(16'hE0E0, k);
        @(negedge clk);
        bus.d_write = 1'b1; bus.d_addr = 32'h4000_0008;
        bus.d_wdata = {w[3], w[2], w[1], w[0]};
        for (int c = 0; c < 7; c++) begin
            if (c != 0) @(negedge clk);
            bus.bmem_ready = pat[c];
            if (c == 1) begin
                bus.i_read = 1'b1; bus.i_addr = 32'h5000;
            end
            #1;
            total++; if (bus.bmem_write !== 1'b1 || bus.bmem_read !== 1'b0 ||
                         bus.bmem_wdata !== w[idx] || bus.bmem_addr !== 32'h4000_0000) begin
                bad++; $display("FAIL wr_beat c%0d: got w=%b r=%b d=%h a=%h want 1 0 %h 40000000", c,
                                bus.bmem_write, bus.bmem_read, bus.bmem_wdata, bus.bmem_addr, w[idx]); end
            total++; if (bus.d_resp !== 1'b0) begin
                bad++; $display("FAIL wr_early_resp c%0d: got %b want 0", c, bus.d_resp); end
            if (pat[c]) idx++;
        end
        total++; if (idx != 4) begin
            bad++; $display("FAIL wr_count: got %0d want 4", idx); end
        @(negedge clk);
        #1;
        total++; if (bus.d_resp !== 1'b1 || bus.bmem_write !== 1'b0 || bus.bmem_read !== 1'b0) begin
            bad++; $display("FAIL wr_done: got resp=%b w=%b r=%b want 1 0 0", bus.d_resp,
                            bus.bmem_write, bus.bmem_read); end
        bus.d_write = 1'b0;
        @(negedge clk);
        #1;
        total++; if (bus.bmem_read !== 1'b1 || bus.bmem_addr !== 32'h5000 || bus.d_resp !== 1'b0) begin
            bad++; $display("FAIL wr_after: got r=%b a=%h d=%b want 1 00005000 0", bus.bmem_read,
                            bus.bmem_addr, bus.d_resp); end
        @(negedge clk);
        bus.bmem_ready = 1'b0;
        send_burst(32'h5000, 16'hB1B1);
        #1;
        total++; if (bus.i_resp !== 1'b1 || bus.i_rdata !== lv(16'hB1B1)) begin
            bad++; $display("FAIL wr_iresp: got i=%b data=%h want 1 %h", bus.i_resp, bus.i_rdata,
                            lv(16'hB1B1)); end
        bus.i_read = 1'b0;
    endtask

    task automatic test_out_of_order();
        @(negedge clk);
        bus.i_read = 1'b1; bus.i_addr = 32'h100; bus.bmem_ready = 1'b1;
        #1;
        total++; if (bus.bmem_read !== 1'b1 || bus.bmem_addr !== 32'h100) begin
            bad++; $display("FAIL ooo_i: got r=%b a=%h want 1 00000100", bus.bmem_read, bus.bmem_addr); end
        @(negedge clk);
        bus.d_read = 1'b1; bus.d_addr = 32'h200;
        #1;
        total++; if (bus.bmem_read !== 1'b1 || bus.bmem_addr !== 32'h200) begin
            bad++; $display("FAIL ooo_d: got r=%b a=%h want 1 00000200", bus.bmem_read, bus.bmem_addr); end
        @(negedge clk);
        bus.bmem_ready = 1'b0;
        send_burst(32'h200, 16'h2222);
        #1;
        total++; if (bus.d_resp !== 1'b1 || bus.d_rdata !== lv(16'h2222) || bus.i_resp !== 1'b0) begin
            bad++; $display("FAIL ooo_first: got d=%b i=%b data=%h want 1 0 %h", bus.d_resp, bus.i_resp,
                            bus.d_rdata, lv(16'h2222)); end
        bus.d_read = 1'b0;
        send_burst(32'h100, 16'h1111);
        #1;
        total++; if (bus.i_resp !== 1'b1 || bus.i_rdata !== lv(16'h1111) || bus.d_resp !== 1'b0) begin
            bad++; $display("FAIL ooo_second: got i=%b d=%b data=%h want 1 0 %h", bus.i_resp, bus.d_resp,
                            bus.i_rdata, lv(16'h1111)); end
        bus.i_read = 1'b0;
    endtask

    task automatic test_same_line();
        @(negedge clk);
        bus.i_read = 1'b1; bus.i_addr = 32'h300;
        bus.d_read = 1'b1; bus.d_addr = 32'h300; bus.bmem_ready = 1'b1;
        #1;
        total++; if (bus.bmem_read !== 1'b1 || bus.bmem_addr !== 32'h300) begin
            bad++; $display("FAIL same_c0: got r=%b a=%h want 1 00000300", bus.bmem_read, bus.bmem_addr); end
        @(negedge clk);
        #1;
        total++; if (bus.bmem_read !== 1'b1 || bus.bmem_addr !== 32'h300) begin
            bad++; $display("FAIL same_c1: got r=%b a=%h want 1 00000300", bus.bmem_read, bus.bmem_addr); end
        @(negedge clk);
        bus.bmem_ready = 1'b0;
        send_burst(32'h300, 16'h3333);
        #1;
        total++; if (bus.i_resp !== 1'b1 || bus.d_resp !== 1'b1) begin
            bad++; $display("FAIL same_resp: got i=%b d=%b want 1 1", bus.i_resp, bus.d_resp); end
        total++; if (bus.i_rdata !== lv(16'h3333) || bus.d_rdata !== lv(16'h3333)) begin
            bad++; $display("FAIL same_data: got i=%h d=%h want %h", bus.i_rdata, bus.d_rdata,
                            lv(16'h3333)); end
        total++; if (dut.rx_drop !== 32'd0) begin
            bad++; $display("FAIL same_drop: got %0d want 0", dut.rx_drop); end
        bus.i_read = 1'b0; bus.d_read = 1'b0;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        bus.i_read = 1'b1; bus.i_addr = 32'h600; bus.bmem_ready = 1'b1;
        @(negedge clk);
        bus.d_write = 1'b1; bus.d_addr = 32'h700; bus.d_wdata = lv(16'h7777);
        #1;
        total++; if (bus.bmem_write !== 1'b1 || bus.bmem_wdata !== bv(16'h7777, 0)) begin
            bad++; $display("FAIL rmid_beat0: got w=%b d=%h want 1 %h", bus.bmem_write, bus.bmem_wdata,
                            bv(16'h7777, 0)); end
        @(negedge clk);
        #1;
        total++; if (bus.bmem_write !== 1'b1 || bus.bmem_wdata !== bv(16'h7777, 1)) begin
            bad++; $display("FAIL rmid_beat1: got w=%b d=%h want 1 %h", bus.bmem_write, bus.bmem_wdata,
                            bv(16'h7777, 1)); end
        #1;
        rst = 1'b1;
        #1;
        total++; if (bus.bmem_write !== 1'b0 || bus.bmem_read !== 1'b0 || bus.bmem_addr !== 32'h0 ||
                     bus.bmem_wdata !== '0) begin
            bad++; $display("FAIL rmid_out: got w=%b r=%b a=%h want 0 0 0", bus.bmem_write,
                            bus.bmem_read, bus.bmem_addr); end
        bus.i_read = 1'b0; bus.d_write = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        send_burst(32'h600, 16'h6666);
        #1;
        total++; if (bus.i_resp !== 1'b0 || bus.d_resp !== 1'b0) begin
            bad++; $display("FAIL rmid_resp: got i=%b d=%b want 0 0", bus.i_resp, bus.d_resp); end
        total++; if (dut.rx_drop !== 32'd4) begin
            bad++; $display("FAIL rmid_drop: got %0d want 4", dut.rx_drop); end
    endtask

    initial begin
        bus.i_addr = '0; bus.i_read = 1'b0;
        bus.d_addr = '0; bus.d_read = 1'b0; bus.d_write = 1'b0; bus.d_wdata = '0;
        bus.bmem_ready = 1'b0; bus.bmem_raddr = '0; bus.bmem_rdata = '0; bus.bmem_rvalid = 1'b0;
        test_reset();
        test_icache_read();
        test_tie();
        test_write_stall();
        test_out_of_order();
        test_same_line();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
